// File: rtl/wb_ctrl_pkg.sv
// Shared encodings, register map and commit FSM states
// for the white balance control sequencer.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO_GW     = 2'd0,
    MODE_AUTO_R      = 2'd1,
    MODE_MANUAL      = 2'd2,
    MODE_CALIBRATION = 2'd3
  } wb_mode_e;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } wb_sel_e;

  localparam logic [2:0] ADDR_MODE      = 3'd0;
  localparam logic [2:0] ADDR_R         = 3'd1;
  localparam logic [2:0] ADDR_G         = 3'd2;
  localparam logic [2:0] ADDR_B         = 3'd3;
  localparam logic [2:0] ADDR_COMMIT    = 3'd4;
  localparam logic [2:0] ADDR_CAL_START = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_R,
    ST_SEND_G,
    ST_SEND_B
  } commit_state_e;

endpackage

// File: rtl/wb_ctrl_if.sv
// Control bundle from the sequencer to the
// white balance corrector.
interface wb_ctrl_if;
  logic [1:0]  mode;
  logic [1:0]  man_sel;
  logic [31:0] man_coef;
  logic        man_lock;
  logic        cal_stb;

  modport master (
    output mode, man_sel, man_coef,
    output man_lock, cal_stb
  );

  modport slave (
    input mode, man_sel, man_coef,
    input man_lock, cal_stb
  );
endinterface

// File: rtl/wb_ctrl_sof_counter.sv
// SOF detect plus the calibration frame counter,
// cal_stb pulse and calibration status flags.
module wb_ctrl_sof_counter #(
  parameter int CAL_FRAMES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic video_tvalid_i,
  input  logic video_tready_i,
  input  logic video_tuser_i,
  input  logic cal_start_i,
  input  logic cal_abort_i,
  output logic sof_o,
  output logic cal_enter_o,
  output logic cal_stb_o,
  output logic cal_active_o,
  output logic cal_done_o
);

  localparam int CW = $clog2(CAL_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(CAL_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic active_q, active_d;
  logic done_q, done_d;
  logic stb_q, stb_d;

  always_comb begin
    sof_o       = video_tvalid_i && video_tready_i
                  && video_tuser_i;
    cal_enter_o = sof_o && pend_q && !cal_abort_i;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    active_d    = active_q;
    done_d      = done_q;
    stb_d       = 1'b0;
    if (cal_abort_i) begin
      pend_d   = 1'b0;
      active_d = 1'b0;
    end else if (cal_enter_o) begin
      pend_d   = 1'b0;
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (sof_o && active_q) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        stb_d    = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // a fresh start request outranks a completion in the same cycle
    if (cal_start_i) begin
      pend_d = 1'b1;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      done_q   <= done_d;
      stb_q    <= stb_d;
    end
  end

  assign cal_stb_o    = stb_q;
  assign cal_active_o = active_q;
  assign cal_done_o   = done_q;

endmodule

// File: rtl/wb_ctrl_sequencer.sv
// Host CSR to frame-aligned white balance control traffic:
// shadowed mode/gains, SOF-aligned commit burst, calibration.
module wb_ctrl_sequencer
  import wb_ctrl_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int CAL_FRAMES  = 2,
  parameter logic [PX_WIDTH+FRACT_WIDTH-1:0] R_INIT =
    {PX_WIDTH'(1), FRACT_WIDTH'(119)},
  parameter logic [PX_WIDTH+FRACT_WIDTH-1:0] B_INIT =
    {PX_WIDTH'(1), FRACT_WIDTH'(295)}
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_wr_i,
  input  logic        cfg_rd_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        video_tvalid_i,
  input  logic        video_tready_i,
  input  logic        video_tuser_i,
  wb_ctrl_if.master   wb_ctrl_o
);

  localparam int CW = PX_WIDTH + FRACT_WIDTH;
  localparam logic [CW-1:0] FIXED_ONE =
    {PX_WIDTH'(1), FRACT_WIDTH'(0)};

  commit_state_e state_q, state_d;
  logic [1:0]    mode_sh_q, mode_sh_d;
  logic [CW-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d;
  logic [CW-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0] snap_g_q, snap_g_d, snap_b_q, snap_b_d;
  logic          pend_q, pend_d;
  logic          hold_q, hold_d;
  logic [1:0]    mode_q, mode_d, sel_q, sel_d;
  logic [31:0]   coef_q, coef_d, rdata_q, rdata_d;
  logic          lock_q, lock_d;

  logic wr_mode, wr_r, wr_g, wr_b, wr_commit, wr_cal;
  logic sof, cal_enter, cal_stb, cal_active, cal_done;
  logic busy, commit_go;

  wb_ctrl_sof_counter #(
    .CAL_FRAMES(CAL_FRAMES)
  ) u_sof (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .video_tvalid_i(video_tvalid_i),
    .video_tready_i(video_tready_i),
    .video_tuser_i (video_tuser_i),
    .cal_start_i   (wr_cal),
    .cal_abort_i   (wr_mode),
    .sof_o         (sof),
    .cal_enter_o   (cal_enter),
    .cal_stb_o     (cal_stb),
    .cal_active_o  (cal_active),
    .cal_done_o    (cal_done)
  );

  always_comb begin
    wr_mode   = cfg_wr_i && (cfg_addr_i == ADDR_MODE);
    wr_r      = cfg_wr_i && (cfg_addr_i == ADDR_R);
    wr_g      = cfg_wr_i && (cfg_addr_i == ADDR_G);
    wr_b      = cfg_wr_i && (cfg_addr_i == ADDR_B);
    wr_commit = cfg_wr_i && (cfg_addr_i == ADDR_COMMIT);
    wr_cal    = cfg_wr_i && (cfg_addr_i == ADDR_CAL_START);
    busy      = (state_q != ST_IDLE);
    commit_go = !busy && pend_q && sof;
  end

  always_comb begin
    state_d   = state_q;
    mode_sh_d = wr_mode ? cfg_wdata_i[1:0] : mode_sh_q;
    sh_r_d    = wr_r ? cfg_wdata_i[CW-1:0] : sh_r_q;
    sh_g_d    = wr_g ? cfg_wdata_i[CW-1:0] : sh_g_q;
    sh_b_d    = wr_b ? cfg_wdata_i[CW-1:0] : sh_b_q;
    snap_g_d  = snap_g_q;
    snap_b_d  = snap_b_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    coef_d    = coef_q;
    lock_d    = 1'b0;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (commit_go) begin
          snap_g_d = sh_g_q;
          snap_b_d = sh_b_q;
          pend_d   = 1'b0;
          lock_d   = 1'b1;
          sel_d    = SEL_R;
          coef_d   = 32'(sh_r_q);
          state_d  = ST_SEND_R;
        end
      end
      ST_SEND_R: begin
        lock_d  = 1'b1;
        sel_d   = SEL_G;
        coef_d  = 32'(snap_g_q);
        state_d = ST_SEND_G;
      end
      ST_SEND_G: begin
        lock_d  = 1'b1;
        sel_d   = SEL_B;
        coef_d  = 32'(snap_b_q);
        state_d = ST_SEND_B;
      end
      ST_SEND_B: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (wr_commit) pend_d = 1'b1;

    // calibration mode sticks until the host writes MODE again
    if (cal_enter) begin
      mode_d = MODE_CALIBRATION;
      hold_d = 1'b1;
    end else if (sof && !hold_q) begin
      mode_d = mode_sh_q;
    end
    if (wr_mode) hold_d = 1'b0;

    if (cfg_rd_i) begin
      unique case (cfg_addr_i)
        ADDR_MODE:   rdata_d = {30'd0, mode_sh_q};
        ADDR_R:      rdata_d = 32'(sh_r_q);
        ADDR_G:      rdata_d = 32'(sh_g_q);
        ADDR_B:      rdata_d = 32'(sh_b_q);
        ADDR_STATUS: rdata_d = {28'd0, cal_done,
                                cal_active, pend_q, busy};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mode_sh_q <= 2'd0;
      sh_r_q    <= R_INIT;
      sh_g_q    <= FIXED_ONE;
      sh_b_q    <= B_INIT;
      snap_g_q  <= '0;
      snap_b_q  <= '0;
      pend_q    <= 1'b0;
      hold_q    <= 1'b0;
      mode_q    <= 2'd0;
      sel_q     <= 2'd0;
      coef_q    <= 32'd0;
      lock_q    <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      mode_sh_q <= mode_sh_d;
      sh_r_q    <= sh_r_d;
      sh_g_q    <= sh_g_d;
      sh_b_q    <= sh_b_d;
      snap_g_q  <= snap_g_d;
      snap_b_q  <= snap_b_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      coef_q    <= coef_d;
      lock_q    <= lock_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cfg_rdata_o        = rdata_q;
  assign wb_ctrl_o.mode     = mode_q;
  assign wb_ctrl_o.man_sel  = sel_q;
  assign wb_ctrl_o.man_coef = coef_q;
  assign wb_ctrl_o.man_lock = lock_q;
  assign wb_ctrl_o.cal_stb  = cal_stb;

endmodule

// File: tb/tb_wb_ctrl_sequencer.sv
// Directed checks of the white balance control sequencer.
module tb_wb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tvalid = 1'b0;
  logic        tready = 1'b0;
  logic        tuser = 1'b0;

  int total = 0;
  int bad = 0;

  wb_ctrl_if ctrl ();

  wb_ctrl_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_wr_i      (wr),
    .cfg_rd_i      (rd),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .cfg_rdata_o   (rdata),
    .video_tvalid_i(tvalid),
    .video_tready_i(tready),
    .video_tuser_i (tuser),
    .wb_ctrl_o     (ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a,
                        input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a,
                        output logic [31:0] d);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic sof();
    tvalid = 1'b1; tready = 1'b1; tuser = 1'b1;
    tick();
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({ctrl.mode, ctrl.man_sel, ctrl.man_lock, ctrl.cal_stb} !== 6'd0
        || ctrl.man_coef !== 32'd0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_outputs: mode=%0d sel=%0d lock=%b stb=%b coef=%h rdata=%h want all 0",
               ctrl.mode, ctrl.man_sel, ctrl.man_lock, ctrl.cal_stb,
               ctrl.man_coef, rdata);
    end
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", v); end
    rd_reg(3'd1, v);
    total++;
    if (v !== 32'h477) begin bad++; $display("FAIL rst_r: got %h want 477", v); end
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'h400) begin bad++; $display("FAIL rst_g: got %h want 400", v); end
    rd_reg(3'd3, v);
    total++;
    if (v !== 32'h527) begin bad++; $display("FAIL rst_b: got %h want 527", v); end
    rd_reg(3'd7, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL rd_unknown: got %h want 0", v); end
  endtask

  task automatic test_commit();
    logic [31:0] v;
    // write and read R in the same cycle: old value comes back
    wr = 1'b1; rd = 1'b1; addr = 3'd1; wdata = 32'h500;
    tick();
    wr = 1'b0; rd = 1'b0;
    total++;
    if (rdata !== 32'h477) begin bad++; $display("FAIL rd_during_wr: got %h want 477", rdata); end
    wr_reg(3'd2, 32'h400);
    wr_reg(3'd3, 32'h600);
    wr_reg(3'd7, 32'h3);
    wr_reg(3'd4, 32'h0);
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h2) begin bad++; $display("FAIL commit_pend: got %h want 2", v); end
    tick();
    total++;
    if (ctrl.man_lock !== 1'b0) begin bad++; $display("FAIL lock_before_sof: got %b want 0", ctrl.man_lock); end
    sof();
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b100 || ctrl.man_coef !== 32'h500) begin
      bad++;
      $display("FAIL burst_r: lock=%b sel=%0d coef=%h want 1 0 500",
               ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    rd = 1'b1; addr = 3'd6;
    tick();
    rd = 1'b0;
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b101 || ctrl.man_coef !== 32'h400) begin
      bad++;
      $display("FAIL burst_g: lock=%b sel=%0d coef=%h want 1 1 400",
               ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    total++;
    if (rdata !== 32'h1) begin bad++; $display("FAIL busy: got %h want 1", rdata); end
    // shadow change mid-burst must not leak into this burst
    wr_reg(3'd3, 32'h7ff);
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b110 || ctrl.man_coef !== 32'h600) begin
      bad++;
      $display("FAIL burst_b: lock=%b sel=%0d coef=%h want 1 2 600",
               ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    tick();
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b010 || ctrl.man_coef !== 32'h600) begin
      bad++;
      $display("FAIL burst_end: lock=%b sel=%0d coef=%h want 0 2 600",
               ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL idle_status: got %h want 0", v); end
    total++;
    if (ctrl.mode !== 2'd0) begin bad++; $display("FAIL mode_commit: got %0d want 0", ctrl.mode); end
    wr_reg(3'd3, 32'h600);
  endtask

  task automatic test_mode();
    wr_reg(3'd0, 32'h2);
    tick(); tick();
    total++;
    if (ctrl.mode !== 2'd0) begin bad++; $display("FAIL mode_pre_sof: got %0d want 0", ctrl.mode); end
    sof();
    total++;
    if (ctrl.mode !== 2'd2 || ctrl.man_lock !== 1'b0) begin
      bad++;
      $display("FAIL mode_sof: mode=%0d lock=%b want 2 0", ctrl.mode, ctrl.man_lock);
    end
  endtask

  task automatic test_cal();
    logic [31:0] v;
    wr_reg(3'd5, 32'h0);
    tick();
    sof();
    total++;
    if (ctrl.mode !== 2'd3 || ctrl.cal_stb !== 1'b0) begin
      bad++;
      $display("FAIL cal_enter: mode=%0d stb=%b want 3 0", ctrl.mode, ctrl.cal_stb);
    end
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h4) begin bad++; $display("FAIL cal_active: got %h want 4", v); end
    sof();
    total++;
    if (ctrl.cal_stb !== 1'b0) begin bad++; $display("FAIL cal_early: got %b want 0", ctrl.cal_stb); end
    tick();
    sof();
    total++;
    if (ctrl.cal_stb !== 1'b1) begin bad++; $display("FAIL cal_stb: got %b want 1", ctrl.cal_stb); end
    tick();
    total++;
    if (ctrl.cal_stb !== 1'b0) begin bad++; $display("FAIL cal_stb_width: got %b want 0", ctrl.cal_stb); end
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h8) begin bad++; $display("FAIL cal_done: got %h want 8", v); end
    sof();
    total++;
    if (ctrl.mode !== 2'd3 || ctrl.cal_stb !== 1'b0) begin
      bad++;
      $display("FAIL cal_mode_hold: mode=%0d stb=%b want 3 0", ctrl.mode, ctrl.cal_stb);
    end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    wr_reg(3'd5, 32'h0);
    sof();
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h4) begin bad++; $display("FAIL abort_pre: got %h want 4", v); end
    wr_reg(3'd0, 32'h1);
    rd_reg(3'd6, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL abort_status: got %h want 0", v); end
    sof();
    total++;
    if (ctrl.mode !== 2'd1 || ctrl.cal_stb !== 1'b0) begin
      bad++;
      $display("FAIL abort_mode: mode=%0d stb=%b want 1 0", ctrl.mode, ctrl.cal_stb);
    end
    sof();
    total++;
    if (ctrl.cal_stb !== 1'b0) begin bad++; $display("FAIL abort_nostb: got %b want 0", ctrl.cal_stb); end
  endtask

  task automatic test_back_to_back();
    wr_reg(3'd1, 32'h111);
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd5, 32'h0);
    sof();
    total++;
    if (ctrl.mode !== 2'd3 || {ctrl.man_lock, ctrl.man_sel} !== 3'b100
        || ctrl.man_coef !== 32'h111) begin
      bad++;
      $display("FAIL b2b_start: mode=%0d lock=%b sel=%0d coef=%h want 3 1 0 111",
               ctrl.mode, ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    tick(); tick();
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b110 || ctrl.man_coef !== 32'h600) begin
      bad++;
      $display("FAIL b2b_b: lock=%b sel=%0d coef=%h want 1 2 600",
               ctrl.man_lock, ctrl.man_sel, ctrl.man_coef);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr_reg(3'd4, 32'h0);
    sof();
    tick();
    total++;
    if ({ctrl.man_lock, ctrl.man_sel} !== 3'b101) begin
      bad++;
      $display("FAIL mid_send_g: lock=%b sel=%0d want 1 1", ctrl.man_lock, ctrl.man_sel);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (ctrl.man_lock !== 1'b0 || ctrl.mode !== 2'd0) begin
      bad++;
      $display("FAIL async_rst: lock=%b mode=%0d want 0 0", ctrl.man_lock, ctrl.mode);
    end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    total++;
    if (ctrl.man_lock !== 1'b0 || ctrl.man_coef !== 32'd0) begin
      bad++;
      $display("FAIL no_resume: lock=%b coef=%h want 0 0", ctrl.man_lock, ctrl.man_coef);
    end
    rd_reg(3'd1, v);
    total++;
    if (v !== 32'h477) begin bad++; $display("FAIL rst_mid_r: got %h want 477", v); end
    rd_reg(3'd3, v);
    total++;
    if (v !== 32'h527) begin bad++; $display("FAIL rst_mid_b: got %h want 527", v); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_mode();
    test_cal();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ctrl_sequencer.md
Name: wb_ctrl_sequencer

Overview:
- Master end of wb_ctrl_if. Turns host register writes into frame-aligned control traffic for the white balance corrector.
- Holds shadow copies of the mode and of the manual R/G/B gains. Commits them on start-of-frame (SOF) so a gain change never tears a frame.
- Runs the calibration sequence: switch to calibration mode, let the gray-world statistics settle for CAL_FRAMES frames, then pulse cal_stb.
- Sits between the CSR bridge and the corrector. Snoops the corrector's input stream handshake to find SOF.

Parameters:
- PX_WIDTH, 10, pixel width; sets the coefficient integer part.
- FRACT_WIDTH, 10, coefficient fractional bits.
- CAL_FRAMES, 2, SOFs counted in calibration mode before cal_stb fires; must be >= 1.
- R_INIT, {PX_WIDTH'(1), FRACT_WIDTH'(119)}, reset value of the red shadow.
- B_INIT, {PX_WIDTH'(1), FRACT_WIDTH'(295)}, reset value of the blue shadow.

Ports:
- clk_i  in  1  clock; the block runs on one clock only.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_wr_i  in  1  register write strobe.
- cfg_rd_i  in  1  register read strobe.
- cfg_addr_i  in  3  register address.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, one cycle after cfg_rd_i.
- video_tvalid_i  in  1  snoop of the corrector input tvalid.
- video_tready_i  in  1  snoop of the corrector input tready.
- video_tuser_i  in  1  snoop of the corrector input tuser (SOF flag).
- wb_ctrl_o  wb_ctrl_if.master  -  mode[1:0], man_sel[1:0], man_coef[31:0], man_lock, cal_stb.

Behaviour:
- Definitions:
  - COEF_WIDTH = PX_WIDTH + FRACT_WIDTH.
  - sof = video_tvalid_i && video_tready_i && video_tuser_i, sampled at the rising edge (cycle T).
- Register map:
  - 0 MODE: bits[1:0], written to mode_shadow.
  - 1/2/3 R/G/B: bits[COEF_WIDTH-1:0], written to the shadows.
  - 4 COMMIT: any write sets commit_pend.
  - 5 CAL_START: any write sets cal_pend and clears cal_done.
  - 6 STATUS, read-only: {28'0, cal_done, cal_active, commit_pend, busy}.
  - Writes to unknown addresses are ignored.
  - Reads of unknown addresses return 0.
- Reset values:
  - mode=0, man_sel=0, man_coef=0, man_lock=0, cal_stb=0, cfg_rdata_o=0.
  - Shadows: R_INIT, FIXED_ONE (green), B_INIT.
  - mode_shadow=0; all pending, active and done flags 0.
  - FSM in IDLE, frame counter 0.
- Commit FSM, states IDLE, SEND_R, SEND_G, SEND_B:
  - IDLE with commit_pend && sof at T: snapshot the three shadows, clear commit_pend, go to SEND_R.
  - Drive man_lock=1 in T+1, T+2 and T+3, with man_sel 0/1/2 and man_coef = zero-extended snapshot R/G/B respectively.
  - man_lock=0 otherwise; man_sel and man_coef hold their last values.
  - busy=1 outside IDLE.
  - Shadow writes during SEND use the new value only on the next commit.
  - A COMMIT write during SEND sets commit_pend again.
- Mode path:
  - At sof (T) with cal_active=0, mode <= mode_shadow at T+1.
  - A MODE write during calibration aborts it: cal_active=0 and cal_pend=0; the next sof applies mode_shadow.
- Calibration:
  - cal_pend && sof at T0: mode <= 3 at T0+1, cal_active=1, cal_pend=0, counter=0.
  - Each further sof increments the counter.
  - On the sof where the counter reaches CAL_FRAMES: cal_stb=1 for exactly one cycle, the following cycle.
  - In that same cycle cal_active=0 and cal_done=1 (sticky).
  - mode stays 3 until a later MODE write plus sof.
  - CAL_START while cal_active restarts the count at the next sof.
- Simultaneous events:
  - A commit and a calibration entry on the same sof both proceed; they are independent paths.
  - A sof during SEND_* is ignored by the commit FSM but still counts for calibration and mode.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No partial man_lock burst is resumed.
- cfg_wr_i and cfg_rd_i may assert in the same cycle. A read of a register being written returns the old value.

Decomposition:
- Package wb_ctrl_pkg holds:
  - the mode encodings (AUTO_GW=0, AUTO_R=1, MANUAL=2, CALIBRATION=3) and the man_sel encodings (R=0, G=1, B=2), shared with the corrector;
  - the register address constants;
  - the commit FSM state enum.
- Sub-module wb_ctrl_sof_counter: the sof detect, calibration frame counter, cal_stb pulse and cal_active/cal_done flags.

Test Plan:
- Reset, read STATUS and registers 1..3 -> STATUS=0, R=0x477, G=0x400, B=0x527; all wb_ctrl outputs 0.
- Write R=0x500, G=0x400, B=0x600, COMMIT, then sof at T -> man_lock high at T+1..T+3 with (sel,coef) = (0,0x500), (1,0x400), (2,0x600); busy=1 during the burst.
- Write MODE=2; mode stays 0 until the sof at T, then mode=2 at T+1 with no man_lock.
- CAL_FRAMES=2, CAL_START, three sofs -> mode=3 after the first sof, cal_stb one cycle after the third sof, STATUS.cal_done=1.
- Calibration in progress, write MODE=1, next sof -> no cal_stb, mode=1, cal_active=0.
- Assert rst_i in the middle of SEND_G -> man_lock drops asynchronously, no SEND_B afterwards, shadows return to their reset values.
